// File: rtl/enemy_ai.sv
// Enemy action generator: priority policy plus 16-bit Galois LFSR picks one action per decision window.
// Optional macro ENEMY_AI_AGGRO_EN adds hp inputs that halve the cooldown while the enemy leads on hp.
module enemy_ai #(
  parameter int unsigned POS_WIDTH     = 11,
  parameter int unsigned DECIDE_PERIOD = 16,
  parameter int unsigned MOVE_CYCLES   = 8,
  parameter int unsigned HOLD_CYCLES   = 6,
  parameter int unsigned ATTACK_RANGE  = 200,
  parameter int unsigned DODGE_RANGE   = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           i_state,
  input  logic [POS_WIDTH-1:0] i_player_x,
  input  logic [POS_WIDTH-1:0] i_enemy_x,
  input  logic [POS_WIDTH-1:0] i_goodbullet_x,
  input  logic                 i_goodbullet_isE,
  input  logic                 i_badbullet_isE,
`ifdef ENEMY_AI_AGGRO_EN
  input  logic [1:0]           i_player_hp,
  input  logic [1:0]           i_enemy_hp,
`endif
  output logic                 o_right,
  output logic                 o_left,
  output logic                 o_jump,
  output logic                 o_squat,
  output logic                 o_attack,
  output logic                 o_defend
);

  localparam int unsigned DW          = POS_WIDTH + 1;
  localparam int unsigned MAX_MH      = (MOVE_CYCLES > HOLD_CYCLES) ? MOVE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_MAX     = (DECIDE_PERIOD > MAX_MH) ? DECIDE_PERIOD : MAX_MH;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned HALF_PERIOD = ((DECIDE_PERIOD / 2) >= 1) ? (DECIDE_PERIOD / 2) : 1;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_THINK  = 3'd1,
    S_MOVE   = 3'd2,
    S_JUMP   = 3'd3,
    S_SQUAT  = 3'd4,
    S_ATTACK = 3'd5,
    S_DEFEND = 3'd6,
    S_COOL   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic               play;
  logic signed [DW-1:0] pdiff, bdiff;
  logic [DW-1:0]      dxp, dxb;
  logic               player_right;
  logic [CNT_W-1:0]   cool_load;

  assign play = (i_state == 2'b01);

  // Sign-extended differences so extreme positions cannot overflow
  always_comb begin
    pdiff = $signed({i_player_x[POS_WIDTH-1], i_player_x}) - $signed({i_enemy_x[POS_WIDTH-1], i_enemy_x});
    bdiff = $signed({i_goodbullet_x[POS_WIDTH-1], i_goodbullet_x}) - $signed({i_enemy_x[POS_WIDTH-1], i_enemy_x});
    dxp   = pdiff[DW-1] ? ((~pdiff) + DW'(1)) : pdiff;
    dxb   = bdiff[DW-1] ? ((~bdiff) + DW'(1)) : bdiff;
    player_right = !pdiff[DW-1] && (pdiff != '0);
  end

`ifdef ENEMY_AI_AGGRO_EN
  assign cool_load = (i_enemy_hp > i_player_hp) ? CNT_W'(HALF_PERIOD - 1) : CNT_W'(DECIDE_PERIOD - 1);
`else
  assign cool_load = CNT_W'(DECIDE_PERIOD - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    if (!play) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_THINK;
        S_THINK: begin
          if (i_goodbullet_isE && (dxb <= DW'(DODGE_RANGE))) begin
            if (lfsr_q[1:0] == 2'b00) begin
              state_d = S_DEFEND;
              cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end else if (lfsr_q[2]) begin
              state_d = S_JUMP;
            end else begin
              state_d = S_SQUAT;
              cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
          end else if (!i_badbullet_isE && (dxp <= DW'(ATTACK_RANGE))) begin
            state_d = S_ATTACK;
          end else if (dxp != '0) begin
            state_d = S_MOVE;
            cnt_d   = CNT_W'(MOVE_CYCLES - 1);
            dir_d   = player_right ^ (lfsr_q[3:0] == 4'h0);
          end else begin
            state_d = S_COOL;
            cnt_d   = cool_load;
          end
        end
        S_MOVE, S_SQUAT, S_DEFEND: begin
          if (cnt_q == '0) begin
            state_d = S_COOL;
            cnt_d   = cool_load;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_JUMP, S_ATTACK: begin
          state_d = S_COOL;
          cnt_d   = cool_load;
        end
        S_COOL: begin
          if (cnt_q == '0) state_d = S_THINK;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      lfsr_q  <= SEED_EFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Moore decode gated by PLAY so leaving PLAY silences the enemy immediately
  always_comb begin
    o_right  = 1'b0;
    o_left   = 1'b0;
    o_jump   = 1'b0;
    o_squat  = 1'b0;
    o_attack = 1'b0;
    o_defend = 1'b0;
    if (play) begin
      case (state_q)
        S_MOVE: begin
          o_right = dir_q;
          o_left  = !dir_q;
        end
        S_JUMP:   o_jump   = 1'b1;
        S_SQUAT:  o_squat  = 1'b1;
        S_ATTACK: o_attack = 1'b1;
        S_DEFEND: o_defend = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai: decision windows checked cycle by cycle against a small LFSR/policy model.
module tb_enemy_ai;

  localparam int unsigned PW = 11;
  localparam logic [5:0] C_R = 6'b100000;
  localparam logic [5:0] C_L = 6'b010000;
  localparam logic [5:0] C_J = 6'b001000;
  localparam logic [5:0] C_S = 6'b000100;
  localparam logic [5:0] C_A = 6'b000010;
  localparam logic [5:0] C_D = 6'b000001;
  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_THINK = 32'd1;

  logic clk, rst;
  logic [1:0] i_state;
  logic o_right, o_left, o_jump, o_squat, o_attack, o_defend;
  logic [PW-1:0] player_x, enemy_x, gb_x;
  logic gb_en, bb_en;
  int px, ex, gbx;
  logic [15:0] m_lfsr;
  int n_vec, n_err;
  logic [5:0] outs;
`ifdef ENEMY_AI_AGGRO_EN
  logic [1:0] p_hp, e_hp;
`endif

  assign player_x = PW'(px);
  assign enemy_x  = PW'(ex);
  assign gb_x     = PW'(gbx);
  assign outs     = {o_right, o_left, o_jump, o_squat, o_attack, o_defend};

  enemy_ai dut (
    .clk              (clk),
    .rst              (rst),
    .i_state          (i_state),
    .i_player_x       (player_x),
    .i_enemy_x        (enemy_x),
    .i_goodbullet_x   (gb_x),
    .i_goodbullet_isE (gb_en),
    .i_badbullet_isE  (bb_en),
`ifdef ENEMY_AI_AGGRO_EN
    .i_player_hp      (p_hp),
    .i_enemy_hp       (e_hp),
`endif
    .o_right          (o_right),
    .o_left           (o_left),
    .o_jump           (o_jump),
    .o_squat          (o_squat),
    .o_attack         (o_attack),
    .o_defend         (o_defend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // One clock; model LFSR tracks what the DUT register holds after the edge
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) m_lfsr = 16'hACE1;
    else   m_lfsr = lfsr_next(m_lfsr);
  endtask

  function automatic int cool_len();
`ifdef ENEMY_AI_AGGRO_EN
    if (e_hp > p_hp) return 8;
`endif
    return 16;
  endfunction

  function automatic void predict(input logic [15:0] l, output logic [5:0] code, output int len);
    int dxp, dxb;
    logic right;
    dxp = px - ex;
    if (dxp < 0) dxp = -dxp;
    dxb = gbx - ex;
    if (dxb < 0) dxb = -dxb;
    if (gb_en && dxb <= 64) begin
      if (l[1:0] == 2'b00) begin code = C_D; len = 6; end
      else if (l[2])       begin code = C_J; len = 1; end
      else                 begin code = C_S; len = 6; end
    end else if (!bb_en && dxp <= 200) begin
      code = C_A; len = 1;
    end else if (dxp != 0) begin
      right = (px > ex);
      if (l[3:0] == 4'h0) right = !right;
      code = right ? C_R : C_L;
      len = 8;
    end else begin
      code = 6'b0; len = 0;
    end
  endfunction

  // Called while the DUT is in THINK; walks action, cooldown and the next THINK
  task automatic do_window(input string tag);
    logic [5:0] code;
    int len, cl;
    check_eq({tag, "_think_out"}, 32'(outs), 32'd0);
    check_eq({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'(m_lfsr));
    predict(m_lfsr, code, len);
    cl = cool_len();
    for (int i = 0; i < len; i++) begin
      step();
      check_eq({tag, "_act"}, 32'(outs), 32'(code));
    end
    for (int i = 0; i < cl; i++) begin
      step();
      check_eq({tag, "_cool"}, 32'(outs), 32'd0);
    end
    step();
    check_eq({tag, "_next_think"}, 32'(dut.state_q), ST_THINK);
  endtask

  task automatic set_in(input int p, input int e, input logic g, input int gx, input logic b);
    px = p; ex = e; gb_en = g; gbx = gx; bb_en = b;
  endtask

  initial begin
    logic [5:0] code;
    int len;
    n_vec = 0; n_err = 0;
    rst = 1'b1; i_state = 2'b00; m_lfsr = 16'hACE1;
    set_in(0, 0, 1'b0, 0, 1'b0);
`ifdef ENEMY_AI_AGGRO_EN
    p_hp = 2'd0; e_hp = 2'd0;
`endif
    step(); step();
    check_eq("rst_out", 32'(outs), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), ST_IDLE);
    check_eq("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    rst = 1'b0;

    // Idle outside PLAY, LFSR still running
    for (int i = 0; i < 50; i++) begin
      step();
      check_eq("idle_out", 32'(outs), 32'd0);
      check_eq("idle_state", 32'(dut.state_q), ST_IDLE);
      check_eq("idle_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
      if (i == 0) check_eq("lfsr_hand1", 32'(dut.lfsr_q), 32'hE270);
      if (i == 1) check_eq("lfsr_hand2", 32'(dut.lfsr_q), 32'h7138);
      if (i == 2) check_eq("lfsr_hand3", 32'(dut.lfsr_q), 32'h389C);
    end

    set_in(400, 100, 1'b0, 0, 1'b0);
    i_state = 2'b01;
    step();
    check_eq("enter_think", 32'(dut.state_q), ST_THINK);
    do_window("move_far");

    set_in(150, 100, 1'b0, 0, 1'b0); do_window("attack");
    set_in(150, 100, 1'b0, 0, 1'b1); do_window("move_badb");
    for (int k = 0; k < 5; k++) begin
      set_in(150, 100, 1'b1, 130, 1'b0); do_window("dodge");
    end
    set_in(300, 100, 1'b0, 0, 1'b0);    do_window("atk_edge");
    set_in(301, 100, 1'b0, 0, 1'b0);    do_window("atk_over");
    set_in(150, 100, 1'b1, 164, 1'b0);  do_window("dodge_edge");
    set_in(150, 100, 1'b1, 165, 1'b0);  do_window("dodge_over");
    set_in(100, 100, 1'b0, 0, 1'b0);    do_window("same_pos");
    set_in(-300, 100, 1'b0, 0, 1'b0);   do_window("move_neg");
    set_in(-600, -500, 1'b0, 0, 1'b0);  do_window("atk_neg");

    // Leave PLAY mid-move
    set_in(400, 100, 1'b0, 0, 1'b1);
    predict(m_lfsr, code, len);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("abort_act", 32'(outs), 32'(code));
    end
    i_state = 2'b10;
    #1;
    check_eq("abort_same_cycle", 32'(outs), 32'd0);
    step();
    check_eq("abort_idle", 32'(dut.state_q), ST_IDLE);
    check_eq("abort_out", 32'(outs), 32'd0);
    i_state = 2'b01;
    step();
    check_eq("rethink", 32'(dut.state_q), ST_THINK);

    // Reset mid-move; bullet appearing mid-action must be ignored
    predict(m_lfsr, code, len);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq("rstmid_act", 32'(outs), 32'(code));
      if (i == 1) set_in(400, 100, 1'b1, 100, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstmid_out", 32'(outs), 32'd0);
    check_eq("rstmid_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    check_eq("rstmid_state", 32'(dut.state_q), ST_IDLE);
    set_in(400, 100, 1'b0, 0, 1'b1);
    step();
    do_window("post_rst");

`ifdef ENEMY_AI_AGGRO_EN
    e_hp = 2'd3; p_hp = 2'd1;
    set_in(150, 100, 1'b0, 0, 1'b0); do_window("aggro_short");
    e_hp = 2'd1; p_hp = 2'd3;
    set_in(150, 100, 1'b0, 0, 1'b0); do_window("aggro_long");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
